// File: rtl/dly_load_seq.sv
// dly_load_seq: loads the 19 valid byte-lane delay table entries via ld_delay, then pulses set and done.
// Optional macro DLY_SEQ_DIRTY_ONLY_EN: only entries written since their last load are sent.
module dly_load_seq #(
    parameter int SET_GAP = 1
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       wr_err,
    output logic [4:0] dly_addr,
    output logic [7:0] dly_data,
    output logic       ld_delay,
    output logic       set
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, GAP = 3'd2, SET = 3'd3, DONE = 3'd4;
    localparam logic [31:0] VALID = 32'h01ff_03ff;

    logic [2:0]  state;
    logic [2:0]  gcnt;
    logic [7:0]  tbl [32];
    logic [31:0] pend;
    logic [4:0]  from, nxt;
    logic        found, wr_ok, step;

    assign wr_ok = wr_en && !busy;
    assign step  = (state == IDLE && start) || state == LOAD;
    assign from  = state == LOAD ? dly_addr + 5'd1 : 5'd0;

`ifdef DLY_SEQ_DIRTY_ONLY_EN
    logic [31:0] dirty;
    // a write landing in the start cycle must count as dirty for that very sequence
    assign pend = VALID & (dirty | (wr_ok ? 32'd1 << wr_addr : 32'd0));
`else
    assign pend = VALID;
`endif

    // lowest pending address at or above 'from'
    always_comb begin
        found = 1'b0;
        nxt = '0;
        for (int i = 31; i >= 0; i--)
            if (pend[i] && 5'(i) >= from) begin
                found = 1'b1;
                nxt = 5'(i);
            end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
            dly_addr <= '0;
            dly_data <= '0;
            ld_delay <= 1'b0;
            set      <= 1'b0;
            for (int i = 0; i < 32; i++) tbl[i] <= '0;
`ifdef DLY_SEQ_DIRTY_ONLY_EN
            dirty    <= '1;
`endif
        end else begin
            ld_delay <= 1'b0;
            set      <= 1'b0;
            done     <= 1'b0;
            wr_err   <= wr_en && busy;
            if (wr_ok) tbl[wr_addr] <= wr_data;
`ifdef DLY_SEQ_DIRTY_ONLY_EN
            if (wr_ok) dirty[wr_addr] <= 1'b1;
            if (step && found) dirty[nxt] <= 1'b0;
`endif
            if (step) begin
                busy <= 1'b1;
                if (found) begin
                    state    <= LOAD;
                    ld_delay <= 1'b1;
                    dly_addr <= nxt;
                    dly_data <= (wr_ok && wr_addr == nxt) ? wr_data : tbl[nxt];
                end else if (SET_GAP == 0) begin
                    state <= SET;
                    set   <= 1'b1;
                end else begin
                    state <= GAP;
                    gcnt  <= 3'd1;
                end
            end else if (state == GAP) begin
                if (gcnt == 3'(SET_GAP)) begin
                    state <= SET;
                    set   <= 1'b1;
                end else gcnt <= gcnt + 3'd1;
            end else if (state == SET) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
            end else state <= IDLE;
        end
    end
endmodule

// File: tb/tb_dly_load_seq.sv
// tb_dly_load_seq: scoreboard bench driving a SET_GAP=1 and a SET_GAP=0 instance from shared inputs.
module tb_dly_load_seq;
    typedef struct {int c; logic [4:0] a; logic [7:0] d;} ev_t;

`ifdef DLY_SEQ_DIRTY_ONLY_EN
    localparam bit DIRTY = 1'b1;
`else
    localparam bit DIRTY = 1'b0;
`endif

    logic       clk_div = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy [2], done [2], wr_err [2], ld_delay [2], set [2];
    logic [4:0] dly_addr [2];
    logic [7:0] dly_data [2];

    int   cyc = 0, nvec = 0, nbad = 0;
    ev_t  ldq [2][$];
    int   pq [2][3][$];
    int   lo [2], hi [2], dc [2];
    logic [7:0] mt [2][32];
    bit   md [2][32];
    logic [4:0] la [2];
    logic [7:0] ldd [2];
    string pn [3] = '{"set", "done", "wr_err"};

    always #5 clk_div = ~clk_div;
    always @(posedge clk_div) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : lane
        dly_load_seq #(.SET_GAP(g == 0 ? 1 : 0)) u_dut (
            .clk_div(clk_div), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
            .start(start), .busy(busy[g]), .done(done[g]), .wr_err(wr_err[g]),
            .dly_addr(dly_addr[g]), .dly_data(dly_data[g]), .ld_delay(ld_delay[g]), .set(set[g])
        );
    end

    function void chk(string nm, int g, int act, int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s lane%0d cyc%0d: got %0d expected %0d", nm, g, cyc, act, exp);
        end
    endfunction

    // monitor: compares whatever the DUTs present against the queued expectations
    always @(negedge clk_div) begin
        ev_t x;
        logic p;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                chk("rst_outs", g, int'({busy[g], done[g], wr_err[g], ld_delay[g], set[g], dly_addr[g], dly_data[g]}), 0);
                la[g] = '0;
                ldd[g] = '0;
            end else begin
                chk("busy", g, int'(busy[g]), int'(cyc >= lo[g] && cyc <= hi[g]));
                while (ldq[g].size() > 0 && ldq[g][0].c < cyc) begin
                    chk("ld_missing", g, cyc, ldq[g][0].c);
                    void'(ldq[g].pop_front());
                end
                if (ld_delay[g]) begin
                    if (ldq[g].size() == 0) chk("ld_unexpected", g, 1, 0);
                    else begin
                        x = ldq[g].pop_front();
                        chk("ld_cyc", g, cyc, x.c);
                        chk("ld_addr", g, int'(dly_addr[g]), int'(x.a));
                        chk("ld_data", g, int'(dly_data[g]), int'(x.d));
                        la[g] = x.a;
                        ldd[g] = x.d;
                    end
                end else begin
                    chk("hold_addr", g, int'(dly_addr[g]), int'(la[g]));
                    chk("hold_data", g, int'(dly_data[g]), int'(ldd[g]));
                end
                for (int k = 0; k < 3; k++) begin
                    p = k == 0 ? set[g] : k == 1 ? done[g] : wr_err[g];
                    while (pq[g][k].size() > 0 && pq[g][k][0] < cyc) begin
                        chk({pn[k], "_missing"}, g, cyc, pq[g][k][0]);
                        void'(pq[g][k].pop_front());
                    end
                    if (p) chk(pn[k], g, cyc, pq[g][k].size() > 0 ? pq[g][k].pop_front() : -1);
                end
            end
        end
    end

    // one clock of stimulus; the reference model predicts every lane's response to the coming edge
    task automatic step(input bit st, input bit we, input logic [4:0] wa, input logic [7:0] wd);
        int e, k, s;
        start = st;
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        e = cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (we) begin
                if (e - 1 >= lo[g] && e - 1 <= hi[g]) pq[g][2].push_back(e);
                else begin
                    mt[g][wa] = wd;
                    md[g][wa] = 1'b1;
                end
            end
            if (st && e >= dc[g] + 2) begin
                k = 0;
                for (int a = 0; a < 25; a++)
                    if ((a < 10 || a >= 16) && (!DIRTY || md[g][a])) begin
                        ldq[g].push_back('{e + k, 5'(a), mt[g][a]});
                        md[g][a] = 1'b0;
                        k++;
                    end
                s = e + k + (g == 0 ? 1 : 0);
                lo[g] = e;
                hi[g] = s;
                dc[g] = s + 1;
                pq[g][0].push_back(s);
                pq[g][1].push_back(s + 1);
            end
        end
        @(posedge clk_div);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        for (int g = 0; g < 2; g++) begin
            lo[g] = 0;
            hi[g] = -1;
            dc[g] = -100;
            ldq[g].delete();
            for (int k = 0; k < 3; k++) pq[g][k].delete();
            for (int a = 0; a < 32; a++) begin
                mt[g][a] = '0;
                md[g][a] = 1'b1;
            end
        end
        repeat (n) @(posedge clk_div);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        do_reset(3);
        idle(2);
        for (int a = 0; a < 32; a++)
            step(1'b0, 1'b1, 5'(a), (a < 10 || (a >= 16 && a < 25)) ? 8'(a + 8'h40) : 8'hee);
        step(1'b1, 1'b0, '0, '0);
        idle(25);
        step(1'b1, 1'b0, '0, '0);
        idle(4);
        step(1'b0, 1'b1, 5'd3, 8'haa);
        idle(22);
        step(1'b1, 1'b0, '0, '0);
        idle(25);
        step(1'b1, 1'b0, '0, '0);
        idle(5);
        step(1'b1, 1'b0, '0, '0);
        while (cyc < dc[0]) idle(1);
        step(1'b1, 1'b0, '0, '0);
        idle(25);
        step(1'b1, 1'b1, 5'd7, 8'h5a);
        idle(25);
        step(1'b1, 1'b0, '0, '0);
        idle(6);
        do_reset(2);
        step(1'b1, 1'b0, '0, '0);
        idle(25);
        step(1'b0, 1'b1, 5'd5, 8'h11);
        step(1'b0, 1'b1, 5'd20, 8'h22);
        step(1'b1, 1'b0, '0, '0);
        idle(8);
        step(1'b1, 1'b0, '0, '0);
        idle(8);
        repeat (300)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), 8'($urandom));
        idle(30);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/dly_load_seq.md
DLY_LOAD_SEQ -- requirements
Module: dly_load_seq

Interface
REQ-001 SHALL have parameter SET_GAP, default 1 (range 0..7): idle cycles between the last ld_delay pulse and the set pulse.
REQ-002 SHALL have ports:
- clk_div  in  1  free-running half-rate clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write one table entry
- wr_addr  in  5  table address (byte-lane delay address space)
- wr_data  in  8  delay value (3 LSB = fine delay)
- start  in  1  request a full load/apply sequence
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- wr_err  out  1  one-cycle pulse when a write is rejected
- dly_addr  out  5  to byte-lane dly_addr
- dly_data  out  8  to byte-lane dly_data
- ld_delay  out  1  to byte-lane ld_delay
- set  out  1  to byte-lane set
REQ-003 All outputs SHALL be registered on clk_div.

Function
REQ-004 SHALL hold a 32x8 delay table; only the 19 valid addresses are loaded: 0..9 (output delays: DQ0-7, DQS, DM) and 16..24 (input delays: DQ0-7, DQS).
REQ-005 In IDLE, wr_en SHALL write wr_data to table[wr_addr] at the clock edge; writes to invalid addresses (10..15, 25..31) are stored but never loaded.
REQ-006 wr_en while busy=1 SHALL be ignored (table unchanged) and SHALL pulse wr_err one cycle later.
REQ-007 States SHALL be IDLE, LOAD, GAP, SET, DONE.
REQ-008 IDLE->LOAD on start=1: the first ld_delay=1 appears in the cycle after start is sampled, with busy=1 in that same cycle.
REQ-009 LOAD SHALL emit one ld_delay pulse per cycle, back-to-back, in ascending address order 0..9 then 16..24, with dly_addr/dly_data valid in the same cycle as ld_delay.
REQ-010 LOAD->GAP after the last entry; GAP SHALL last SET_GAP cycles (SET_GAP=0 skips GAP); ld_delay=0 in GAP.
REQ-011 SET SHALL assert set for exactly one cycle, then go to DONE.
REQ-012 DONE SHALL assert done=1 and busy=0 for one cycle, then go to IDLE. A start in DONE is ignored.
REQ-013 start while busy=1 SHALL be ignored and not queued.
REQ-014 With start and wr_en in the same IDLE cycle, the write SHALL complete first and the sequence SHALL use the new value.
REQ-015 With SET_GAP=1 and a full load, start sampled at edge N SHALL give: ld_delay at N+1..N+19, GAP at N+20, set at N+21, done at N+22; busy high N+1..N+21.
REQ-016 dly_addr/dly_data SHALL hold their last driven value while ld_delay=0.

Reset
REQ-017 rst=1 SHALL asynchronously force IDLE, clear all table entries to 0, and drive busy=0, done=0, wr_err=0, ld_delay=0, set=0, dly_addr=0, dly_data=0.
REQ-018 rst mid-sequence SHALL abort the sequence with no further ld_delay, set or done pulses.

Configuration
REQ-019 With macro DLY_SEQ_DIRTY_ONLY_EN defined, each valid entry SHALL carry a dirty bit:
- set by reset and by an accepted write
- cleared when the entry is loaded
- LOAD skips clean entries without idle cycles and keeps ascending order
- with no dirty entries, start goes directly to GAP (or to SET if SET_GAP=0); set is still issued
REQ-020 Without DLY_SEQ_DIRTY_ONLY_EN, there SHALL be no dirty state, and all 19 entries SHALL load on every start.

Verification
REQ-021 Write table[a]=a+0x40 for all valid a, start (SET_GAP=1) -> 19 ld_delay pulses with addr 0..9,16..24 and data 0x40..0x49,0x50..0x58; set at N+21; done at N+22.
REQ-022 wr_en (addr 3, data 0xAA) during LOAD -> wr_err pulse next cycle; the next sequence still loads the old table[3].
REQ-023 Second start during LOAD and during DONE -> exactly one sequence completes and exactly one done pulse.
REQ-024 rst asserted at the 7th ld_delay -> all outputs 0 immediately; the next start loads 0x00 for every entry.
REQ-025 SET_GAP=0 -> set in the cycle immediately after the last ld_delay.
REQ-026 DLY_SEQ_DIRTY_ONLY_EN, after a full load, write addr 5 and 20, start -> ld_delay only for 5 then 20 in consecutive cycles, then GAP, set, done; an immediate second start -> no ld_delay, set and done only.
